// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared encodings for the LED pattern generator. It holds the
//               channel mode codes, the heartbeat FSM states and the REST
//               phase length multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  // Channel mode codes, exactly as they appear on cfg_mode
  localparam logic [1:0] MODE_OFF       = 2'd0;
  localparam logic [1:0] MODE_ON        = 2'd1;
  localparam logic [1:0] MODE_BLINK     = 2'd2;
  localparam logic [1:0] MODE_HEARTBEAT = 2'd3;

  // Heartbeat sequence: ON1 -> OFF1 -> ON2 -> REST -> ON1
  typedef enum logic [1:0] {
    HB_ON1  = 2'd0,
    HB_OFF1 = 2'd1,
    HB_ON2  = 2'd2,
    HB_REST = 2'd3
  } hb_state_t;

  // REST lasts REST_MULT*(period+1) ticks, so its limit is REST_MULT*period+3
  localparam int REST_MULT = 4;

endpackage
`default_nettype wire

// File: rtl/led_pattern_chan.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_chan
// Description : One LED channel. It holds the mode and period registers, a
//               phase counter that advances on the shared tick, and the
//               heartbeat FSM. The output is the internal (active-high) level.
// Ports       : clk, rst        - clock, async active-high reset
//               tick            - shared prescaler tick
//               wr_en           - accepted config write for this channel
//               wr_mode         - new mode (led_pkg MODE_*)
//               wr_period       - new phase length in ticks minus 1
//               level           - internal LED level
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_chan
  import led_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr_en,
  input  logic [1:0]       wr_mode,
  input  logic [CNT_W-1:0] wr_period,
  output logic             level
);

  // The counter is two bits wider so the REST limit (4*period+3) never overflows
  localparam int LIM_W = CNT_W + 2;

  logic [1:0]       mode;
  logic [CNT_W-1:0] period;
  logic [LIM_W-1:0] cnt;
  logic [LIM_W-1:0] limit;
  logic             blink_lvl;
  logic             patterned;
  logic             phase_end;
  hb_state_t        hb_state;
  hb_state_t        hb_state_nxt;

  assign patterned = (mode == MODE_BLINK) || (mode == MODE_HEARTBEAT);

  assign limit = (hb_state == HB_REST)
               ? (LIM_W'(REST_MULT) * {2'b00, period}) + LIM_W'(3)
               : {2'b00, period};

  // A write on this channel has priority, so an event in the same cycle is dropped
  assign phase_end = tick && patterned && (cnt == limit) && !wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode      <= MODE_OFF;
      period    <= '0;
      cnt       <= '0;
      blink_lvl <= 1'b0;
    end else if (wr_en) begin
      mode      <= wr_mode;
      period    <= wr_period;
      cnt       <= '0;
      blink_lvl <= 1'b1;
    end else if (tick && patterned) begin
      if (cnt == limit) begin
        cnt       <= '0;
        blink_lvl <= ~blink_lvl;
      end else begin
        cnt <= cnt + LIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_state <= HB_ON1;
    end else begin
      hb_state <= hb_state_nxt;
    end
  end

  always_comb begin
    hb_state_nxt = hb_state;
    if (wr_en) begin
      hb_state_nxt = HB_ON1;
    end else if (phase_end && (mode == MODE_HEARTBEAT)) begin
      case (hb_state)
        HB_ON1:  hb_state_nxt = HB_OFF1;
        HB_OFF1: hb_state_nxt = HB_ON2;
        HB_ON2:  hb_state_nxt = HB_REST;
        default: hb_state_nxt = HB_ON1;
      endcase
    end
  end

  always_comb begin
    level = 1'b0;
    case (mode)
      MODE_ON:        level = 1'b1;
      MODE_BLINK:     level = blink_lvl;
      MODE_HEARTBEAT: level = (hb_state == HB_ON1) || (hb_state == HB_ON2);
      default:        level = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_ctrl
// Description : Multi-channel LED pattern generator. One prescaler produces a
//               tick that all channels share. A valid/ready port writes the
//               mode and period of each channel.
// Ports       : clk, rst        - clock, async active-high reset
//               cfg_valid/ready - config write handshake
//               cfg_sel         - target channel
//               cfg_mode        - 0=OFF 1=ON 2=BLINK 3=HEARTBEAT
//               cfg_period      - phase length in ticks minus 1
//               cfg_err         - one-cycle pulse when a write is rejected
//               led_out         - LED pins, bit i = channel i
// Options     : LED_PATTERN_ACTIVE_LOW_EN - invert led_out for active-low boards
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int N_LED     = 8,
  parameter int CNT_W     = 16,
  parameter int PRESC_DIV = 1000,
  parameter int SEL_W     = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  output logic             cfg_err,
  output logic [N_LED-1:0] led_out
);

  localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic               accept;
  logic               sel_ok;
  logic [N_LED-1:0]   level;

  // Config writes never touch the prescaler, so all channels stay aligned to the global tick
  assign tick = (presc == PRESC_W'(PRESC_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  assign accept = cfg_valid && cfg_ready;
  // The compare is one bit wider, so it still holds when N_LED is a power of two
  assign sel_ok = ({1'b0, cfg_sel} < (SEL_W + 1)'(N_LED));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      cfg_err   <= accept && !sel_ok;
    end
  end

  generate
    for (genvar i = 0; i < N_LED; i++) begin : g_chan
      led_pattern_chan #(
        .CNT_W (CNT_W)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .wr_en     (accept && sel_ok && (cfg_sel == SEL_W'(i))),
        .wr_mode   (cfg_mode),
        .wr_period (cfg_period),
        .level     (level[i])
      );
    end
  endgenerate

`ifdef LED_PATTERN_ACTIVE_LOW_EN
  assign led_out = ~level;
`else
  assign led_out = level;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_led_pattern_ctrl
// Description : Testbench for led_pattern_ctrl. Directed and random config
//               writes drive a reference model that computes each channel
//               level from the tick count since its last write. A monitor
//               compares the expected values it queues with the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

  localparam int N  = 8;
  localparam int CW = 16;
  localparam int PD = 4;
  localparam int SW = 4;   // wide enough to address non-existent channels 8..15

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [SW-1:0] cfg_sel = '0;
  logic [1:0]    cfg_mode = '0;
  logic [CW-1:0] cfg_period = '0;
  logic          cfg_err;
  logic [N-1:0]  led_out;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .N_LED     (N),
    .CNT_W     (CW),
    .PRESC_DIV (PD),
    .SEL_W     (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_sel    (cfg_sel),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_err    (cfg_err),
    .led_out    (led_out)
  );

  typedef struct packed {
    logic [N-1:0] led;
    logic         err;
    logic         rdy;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  // Reference state: mode, period and the number of ticks since the last write
  int     m_mode[N];
  longint m_per[N];
  longint m_k[N];
  int     edge_n;

  function automatic logic [N-1:0] pins(input logic [N-1:0] lv);
`ifdef LED_PATTERN_ACTIVE_LOW_EN
    return ~lv;
`else
    return lv;
`endif
  endfunction

  // The level comes from the elapsed ticks alone. BLINK alternates phases of
  // p+1 ticks each. HEARTBEAT repeats 1 (p+1), 0 (p+1), 1 (p+1), 0 (4p+4).
  function automatic logic ref_level(input int md, input longint p, input longint k);
    longint ph, r;
    ph = p + 1;
    case (md)
      1: return 1'b1;
      2: return ((k / ph) % 2) == 0;
      3: begin
        r = k % (7 * ph);
        return (r < ph) || ((r >= 2 * ph) && (r < 3 * ph));
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = 0;
      m_per[i]  = 0;
      m_k[i]    = 0;
    end
    edge_n = 0;
  endtask

  // Called at a negedge. It drives the inputs for the next posedge and queues
  // the outputs expected after that edge, then waits for the following negedge.
  task automatic drive(input bit v, input int sel, input int md, input int per);
    bit           acc, tk;
    exp_t         e;
    logic [N-1:0] lv;
    cfg_valid  = v;
    cfg_sel    = SW'(sel);
    cfg_mode   = 2'(md);
    cfg_period = CW'(per);
    edge_n++;
    acc = v && (edge_n >= 2);          // ready rises on the first edge after release
    tk  = (edge_n % PD) == 0;          // the prescaler is 0 on the first edge
    for (int i = 0; i < N; i++) begin
      if (acc && sel == i) begin
        m_mode[i] = md;
        m_per[i]  = per;
        m_k[i]    = 0;
      end else if (tk) begin
        m_k[i]++;
      end
      lv[i] = ref_level(m_mode[i], m_per[i], m_k[i]);
    end
    e.led = pins(lv);
    e.err = acc && (sel >= N);
    e.rdy = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(1'b0, 0, 0, 0);
  endtask

  // Monitor: compare one queued expectation per clock, away from the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("led_out",   32'(led_out),   32'(e.led));
        check("cfg_err",   32'(cfg_err),   32'(e.err));
        check("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
      end
    end
  end

  initial begin
    int waited;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset led_out",   32'(led_out),   32'(pins('0)));
    check("reset cfg_ready", 32'(cfg_ready), 32'h0);
    check("reset cfg_err",   32'(cfg_err),   32'h0);

    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 3, 1, 0);              // offered before ready, must be ignored
    idle(2);

    drive(1'b1, 2, 2, 1);              // ch2 BLINK, period 1
    idle(20);
    drive(1'b1, 5, 3, 0);              // ch5 HEARTBEAT, period 0
    idle(30);
    drive(1'b1, 9, 1, 0);              // out-of-range channel
    idle(3);
    drive(1'b1, 0, 2, 0);              // ch0 BLINK, period 0
    idle(6);
    while (((edge_n + 1) % PD) != 0) idle(1);
    drive(1'b1, 0, 1, 0);              // rewrite ch0 ON on a tick edge
    idle(10);
    drive(1'b1, 7, 3, 16'hFFFF);       // largest period
    idle(4);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0)
        drive(1'b1, int'($urandom_range(0, 11)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 15) == 0) ? 16'hFFFF : int'($urandom_range(0, 3)));
      else
        idle(1);
    end

    // Reset in the middle of a heartbeat pattern
    drive(1'b1, 5, 3, 1);
    idle(5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst led_out",   32'(led_out),   32'(pins('0)));
    check("async rst cfg_ready", 32'(cfg_ready), 32'h0);
    check("async rst cfg_err",   32'(cfg_err),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(2);
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 5) == 0)
        drive(1'b1, int'($urandom_range(0, 11)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)));
      else
        idle(1);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
